// File: rtl/style_record_builder_pkg.sv
// Shared definitions for the style record builder: property codes, record
// field layout, display code range and FSM states.
package style_record_builder_pkg;

    localparam int REC_W    = 59;
    localparam int DISP_LSB = 56;
    localparam int DISP_W   = 3;
    localparam int POS_LSB  = 54;
    localparam int POS_W    = 2;
    localparam int FLT_LSB  = 52;
    localparam int FLT_W    = 2;
    localparam int COL_LSB  = 28;
    localparam int COL_W    = 24;
    localparam int WID_LSB  = 12;
    localparam int WID_W    = 16;
    localparam int HGT_LSB  = 0;
    localparam int HGT_W    = 12;

    localparam logic [3:0] PROP_DISPLAY  = 4'd0;
    localparam logic [3:0] PROP_POSITION = 4'd1;
    localparam logic [3:0] PROP_FLOAT    = 4'd2;
    localparam logic [3:0] PROP_COLOR    = 4'd3;
    localparam logic [3:0] PROP_WIDTH    = 4'd4;
    localparam logic [3:0] PROP_HEIGHT   = 4'd5;

    localparam logic [31:0] DISPLAY_MAX = 32'd5;
    localparam logic [31:0] POS_MAX     = 32'd3;
    localparam logic [31:0] FLT_MAX     = 32'd2;
    localparam logic [31:0] WID_SAT     = 32'h0000_FFFF;
    localparam logic [31:0] HGT_SAT     = 32'h0000_0FFF;

    typedef enum logic [1:0] {S_IDLE, S_ACCUM, S_EMIT} state_e;

    function automatic logic [REC_W-1:0] rec_defaults(input logic [DISP_W-1:0] disp);
        logic [REC_W-1:0] r;
        r = '0;
        r[DISP_LSB +: DISP_W] = disp;
        return r;
    endfunction

endpackage

// File: rtl/style_reg_en.sv
// Enabled register cell with synchronous active-low reset to a parameterised value.
module style_reg_en #(
    parameter int              W       = 59,
    parameter logic [W-1:0]    RST_VAL = '0
) (
    input  logic         clk_i,
    input  logic         rst_ni,
    input  logic         en_i,
    input  logic [W-1:0] d_i,
    output logic [W-1:0] q_o
);

    logic [W-1:0] val_q;

    always_ff @(posedge clk_i) begin
        if (!rst_ni)   val_q <= RST_VAL;
        else if (en_i) val_q <= d_i;
    end

    assign q_o = val_q;

endmodule

// File: rtl/style_value_check.sv
// Combinational per-property validation and saturation; produces the updated
// record plus apply/reject flags for one declaration.
module style_value_check
    import style_record_builder_pkg::*;
(
    input  logic [3:0]       prop_i,
    input  logic [31:0]      value_i,
    input  logic             is_prim_i,
    input  logic [REC_W-1:0] rec_i,
    output logic [REC_W-1:0] rec_o,
    output logic             apply_o,
    output logic             reject_o
);

    logic known;

    always_comb begin
        rec_o    = rec_i;
        apply_o  = 1'b0;
        reject_o = 1'b0;
        known    = (prop_i <= PROP_HEIGHT);
        if (known && !is_prim_i) begin
            reject_o = 1'b1;
        end else begin
            case (prop_i)
                PROP_DISPLAY: begin
                    if (value_i <= DISPLAY_MAX) begin
                        rec_o[DISP_LSB +: DISP_W] = value_i[DISP_W-1:0];
                        apply_o = 1'b1;
                    end else reject_o = 1'b1;
                end
                PROP_POSITION: begin
                    if (value_i <= POS_MAX) begin
                        rec_o[POS_LSB +: POS_W] = value_i[POS_W-1:0];
                        apply_o = 1'b1;
                    end else reject_o = 1'b1;
                end
                PROP_FLOAT: begin
                    if (value_i <= FLT_MAX) begin
                        rec_o[FLT_LSB +: FLT_W] = value_i[FLT_W-1:0];
                        apply_o = 1'b1;
                    end else reject_o = 1'b1;
                end
                PROP_COLOR: begin
                    if (value_i[31:24] == 8'd0) begin
                        rec_o[COL_LSB +: COL_W] = value_i[COL_W-1:0];
                        apply_o = 1'b1;
                    end else reject_o = 1'b1;
                end
                // Oversized lengths clamp silently; only malformed values are errors.
                PROP_WIDTH: begin
                    rec_o[WID_LSB +: WID_W] = (value_i > WID_SAT) ? WID_SAT[WID_W-1:0]
                                                                  : value_i[WID_W-1:0];
                    apply_o = 1'b1;
                end
                PROP_HEIGHT: begin
                    rec_o[HGT_LSB +: HGT_W] = (value_i > HGT_SAT) ? HGT_SAT[HGT_W-1:0]
                                                                  : value_i[HGT_W-1:0];
                    apply_o = 1'b1;
                end
                default: ;
            endcase
        end
    end

endmodule

// File: rtl/style_record_builder.sv
// Folds a stream of CSS-like declarations into one packed style record per
// element and hands it downstream with a valid/ready handshake.
module style_record_builder
    import style_record_builder_pkg::*;
#(
    parameter logic [2:0]  DISPLAY_DEFAULT = 3'd1,
    parameter int unsigned MAX_DECLS       = 16
) (
    input  logic             clock_i,
    input  logic             reset_ni,
    input  logic             decl_valid_i,
    output logic             decl_ready_o,
    input  logic [3:0]       decl_prop_i,
    input  logic [31:0]      decl_value_i,
    input  logic             decl_is_primitive_i,
    input  logic             decl_last_i,
    output logic             rec_valid_o,
    input  logic             rec_ready_i,
    output logic [REC_W-1:0] rec_data_o,
    output logic             rec_err_o
);

    localparam logic [7:0]       MAX_Q   = 8'(MAX_DECLS);
    localparam logic [REC_W-1:0] REC_DEF = rec_defaults(DISPLAY_DEFAULT);

    state_e           state_q;
    logic             decl_ready_q;
    logic             rec_valid_q;
    logic             err_q;
    logic [7:0]       cnt_q;
    logic [REC_W-1:0] rec_q;
    logic [REC_W-1:0] rec_d;
    logic [REC_W-1:0] chk_rec;
    logic             chk_apply;
    logic             chk_reject;
    logic             accept;
    logic             drop;
    logic             release_rec;
    logic             rec_en;

    assign accept      = decl_valid_i && decl_ready_q;
    assign drop        = (cnt_q >= MAX_Q);
    assign release_rec = rec_valid_q && rec_ready_i;

    style_value_check u_check (
        .prop_i    (decl_prop_i),
        .value_i   (decl_value_i),
        .is_prim_i (decl_is_primitive_i),
        .rec_i     (rec_q),
        .rec_o     (chk_rec),
        .apply_o   (chk_apply),
        .reject_o  (chk_reject)
    );

    // The record only moves on a valid accepted declaration or on handoff,
    // so it is naturally frozen while waiting in EMIT.
    assign rec_en = (accept && !drop && chk_apply) || release_rec;
    assign rec_d  = release_rec ? REC_DEF : chk_rec;

    style_reg_en #(.W(REC_W), .RST_VAL(REC_DEF)) u_rec (
        .clk_i  (clock_i),
        .rst_ni (reset_ni),
        .en_i   (rec_en),
        .d_i    (rec_d),
        .q_o    (rec_q)
    );

    always_ff @(posedge clock_i) begin
        if (!reset_ni) begin
            state_q      <= S_IDLE;
            decl_ready_q <= 1'b1;
            rec_valid_q  <= 1'b0;
            err_q        <= 1'b0;
            cnt_q        <= 8'd0;
        end else begin
            case (state_q)
                S_IDLE, S_ACCUM: begin
                    if (accept) begin
                        if (cnt_q != 8'hFF) cnt_q <= cnt_q + 8'd1;
                        if (drop || chk_reject) err_q <= 1'b1;
                        if (decl_last_i) begin
                            state_q      <= S_EMIT;
                            rec_valid_q  <= 1'b1;
                            decl_ready_q <= 1'b0;
                        end else begin
                            state_q <= S_ACCUM;
                        end
                    end
                end
                S_EMIT: begin
                    if (rec_ready_i) begin
                        state_q      <= S_IDLE;
                        rec_valid_q  <= 1'b0;
                        decl_ready_q <= 1'b1;
                        err_q        <= 1'b0;
                        cnt_q        <= 8'd0;
                    end
                end
                default: state_q <= S_IDLE;
            endcase
        end
    end

    assign decl_ready_o = decl_ready_q;
    assign rec_valid_o  = rec_valid_q;
    assign rec_data_o   = rec_q;
    assign rec_err_o    = err_q;

endmodule

// File: tb/tb_style_record_builder.sv
// Bench for style_record_builder: table vectors, hand-written corner sequences
// and random elements checked against a field-level reference model.
module tb_style_record_builder;

    localparam logic [2:0] DD  = 3'd1;
    localparam int         MAX = 16;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        decl_valid;
    logic        decl_ready;
    logic [3:0]  decl_prop;
    logic [31:0] decl_value;
    logic        decl_prim;
    logic        decl_last;
    logic        rec_valid;
    logic        rec_ready;
    logic [58:0] rec_data;
    logic        rec_err;

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    style_record_builder #(.DISPLAY_DEFAULT(DD), .MAX_DECLS(MAX)) dut (
        .clock_i             (clk),
        .reset_ni            (rst_n),
        .decl_valid_i        (decl_valid),
        .decl_ready_o        (decl_ready),
        .decl_prop_i         (decl_prop),
        .decl_value_i        (decl_value),
        .decl_is_primitive_i (decl_prim),
        .decl_last_i         (decl_last),
        .rec_valid_o         (rec_valid),
        .rec_ready_i         (rec_ready),
        .rec_data_o          (rec_data),
        .rec_err_o           (rec_err)
    );

    typedef struct {
        logic [2:0]  disp;
        logic [1:0]  pos;
        logic [1:0]  flt;
        logic [23:0] color;
        logic [15:0] width;
        logic [11:0] height;
        bit          err;
    } style_t;

    typedef struct {
        logic [3:0]  prop;
        logic [31:0] value;
        bit          prim;
        logic [58:0] rec;
        bit          err;
    } vec_t;

    function automatic logic [58:0] mk(input logic [2:0] d, input logic [1:0] p,
                                       input logic [1:0] f, input logic [23:0] c,
                                       input logic [15:0] w, input logic [11:0] h);
        return {d, p, f, c, w, h};
    endfunction

    function automatic style_t style_default();
        style_t s;
        s.disp = DD; s.pos = 0; s.flt = 0; s.color = 0; s.width = 0; s.height = 0; s.err = 0;
        return s;
    endfunction

    // Reference: idx is the 0-based position of the declaration in its element.
    function automatic style_t model_decl(input style_t s, input int idx, input logic [3:0] p,
                                          input logic [31:0] v, input bit prim);
        style_t n = s;
        if (idx >= MAX) begin n.err = 1; return n; end
        if (p > 5) return n;
        if (!prim) begin n.err = 1; return n; end
        case (p)
            4'd0: if (v <= 5) n.disp = v[2:0]; else n.err = 1;
            4'd1: if (v <= 3) n.pos = v[1:0]; else n.err = 1;
            4'd2: if (v <= 2) n.flt = v[1:0]; else n.err = 1;
            4'd3: if (v < 32'h0100_0000) n.color = v[23:0]; else n.err = 1;
            4'd4: n.width  = (v > 65535) ? 16'hFFFF : v[15:0];
            default: n.height = (v > 4095) ? 12'hFFF : v[11:0];
        endcase
        return n;
    endfunction

    function automatic logic [58:0] pack(input style_t s);
        return mk(s.disp, s.pos, s.flt, s.color, s.width, s.height);
    endfunction

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    // Present one declaration starting at posedge+1; returns at posedge+1 after acceptance.
    task automatic put(input logic [3:0] p, input logic [31:0] v, input bit prim, input bit last);
        int guard = 0;
        decl_valid = 1; decl_prop = p; decl_value = v; decl_prim = prim; decl_last = last;
        while (!decl_ready && guard < 50) begin
            @(posedge clk); #1; guard++;
        end
        if (guard >= 50) chk("put_timeout", 64'(decl_ready), 64'd1);
        @(posedge clk); #1;
        decl_valid = 0; decl_last = 0;
    endtask

    // Called right after the last declaration was accepted.
    task automatic finish_elem(input string nm, input logic [58:0] erec, input bit eerr,
                               input int stall);
        chk({nm, " valid"}, 64'(rec_valid), 64'd1);
        chk({nm, " data"},  64'(rec_data),  64'(erec));
        chk({nm, " err"},   64'(rec_err),   64'(eerr));
        chk({nm, " ready_lo"}, 64'(decl_ready), 64'd0);
        for (int i = 0; i < stall; i++) begin
            rec_ready = 0;
            @(posedge clk); #1;
            chk({nm, " hold_v"}, 64'(rec_valid), 64'd1);
            chk({nm, " hold_d"}, 64'(rec_data),  64'(erec));
            chk({nm, " hold_e"}, 64'(rec_err),   64'(eerr));
        end
        rec_ready = 1;
        @(posedge clk); #1;
        rec_ready = 0;
        chk({nm, " drained"}, 64'(rec_valid), 64'd0);
        chk({nm, " ready_hi"}, 64'(decl_ready), 64'd1);
    endtask

    vec_t        vecs[12];
    logic [58:0] DEF;
    style_t      m;
    logic [3:0]  rp[$];
    logic [31:0] rv[$];
    bit          rprim[$];

    initial begin
        DEF = mk(DD, 0, 0, 0, 0, 0);
        rst_n = 0; decl_valid = 0; decl_prop = 0; decl_value = 0; decl_prim = 0;
        decl_last = 0; rec_ready = 0;
        repeat (3) @(posedge clk);
        #1 rst_n = 1;
        chk("rst valid", 64'(rec_valid), 64'd0);
        chk("rst err",   64'(rec_err),   64'd0);
        chk("rst data",  64'(rec_data),  64'(DEF));
        chk("rst ready", 64'(decl_ready), 64'd1);

        vecs[0]  = '{4'd0, 32'd2,          1, mk(3'd2, 0, 0, 0, 0, 0), 0};
        vecs[1]  = '{4'd0, 32'd7,          1, DEF, 1};
        vecs[2]  = '{4'd0, 32'd3,          0, DEF, 1};
        vecs[3]  = '{4'd1, 32'd3,          1, mk(DD, 2'd3, 0, 0, 0, 0), 0};
        vecs[4]  = '{4'd1, 32'd4,          1, DEF, 1};
        vecs[5]  = '{4'd2, 32'd2,          1, mk(DD, 0, 2'd2, 0, 0, 0), 0};
        vecs[6]  = '{4'd2, 32'd3,          1, DEF, 1};
        vecs[7]  = '{4'd3, 32'h00AB_CDEF,  1, mk(DD, 0, 0, 24'hABCDEF, 0, 0), 0};
        vecs[8]  = '{4'd3, 32'h0100_0000,  1, DEF, 1};
        vecs[9]  = '{4'd4, 32'd70000,      1, mk(DD, 0, 0, 0, 16'hFFFF, 0), 0};
        vecs[10] = '{4'd5, 32'd5000,       1, mk(DD, 0, 0, 0, 0, 12'hFFF), 0};
        vecs[11] = '{4'd9, 32'd1,          0, DEF, 0};
        for (int i = 0; i < 12; i++) begin
            put(vecs[i].prop, vecs[i].value, vecs[i].prim, 1);
            finish_elem($sformatf("vec%0d", i), vecs[i].rec, vecs[i].err, 0);
        end

        // display then height; record must not appear before last
        put(4'd0, 32'd2, 1, 0);
        chk("seq1 early", 64'(rec_valid), 64'd0);
        put(4'd5, 32'd20, 1, 1);
        finish_elem("seq1", mk(3'd2, 0, 0, 0, 0, 12'd20), 0, 0);

        // cascade overwrite, then 5-cycle backpressure
        put(4'd4, 32'd100, 1, 0);
        put(4'd4, 32'd300, 1, 0);
        put(4'd1, 32'd1, 1, 1);
        finish_elem("stall", mk(DD, 2'd1, 0, 0, 16'd300, 0), 0, 5);
        put(4'd15, 32'd0, 1, 1);
        finish_elem("after_stall", DEF, 0, 0);

        // 17 colors: the 17th is dropped
        for (int i = 1; i <= 16; i++) put(4'd3, 32'h0000_1000 + 32'(i), 1, 0);
        put(4'd3, 32'h0000_FF00, 1, 1);
        finish_elem("overflow", mk(DD, 0, 0, 24'h001010, 0, 0), 1, 1);

        // reset in ACCUM aborts the element
        put(4'd3, 32'h0012_3456, 1, 0);
        put(4'd0, 32'd9, 1, 0);
        rst_n = 0;
        @(posedge clk); #1;
        rst_n = 1;
        chk("abort valid", 64'(rec_valid), 64'd0);
        chk("abort data",  64'(rec_data),  64'(DEF));
        chk("abort err",   64'(rec_err),   64'd0);
        chk("abort ready", 64'(decl_ready), 64'd1);
        put(4'd15, 32'd0, 1, 1);
        finish_elem("post_abort", DEF, 0, 0);

        // reset while a record is pending
        put(4'd5, 32'd9, 1, 1);
        rst_n = 0;
        @(posedge clk); #1;
        rst_n = 1;
        chk("emit_abort valid", 64'(rec_valid), 64'd0);
        chk("emit_abort data",  64'(rec_data),  64'(DEF));

        for (int e = 0; e < 40; e++) begin
            int n;
            n = $urandom_range(1, 20);
            rp.delete(); rv.delete(); rprim.delete();
            m = style_default();
            for (int k = 0; k < n; k++) begin
                int r;
                logic [31:0] v;
                r = $urandom_range(0, 2);
                v = (r == 0) ? 32'($urandom_range(0, 7)) :
                    (r == 1) ? 32'($urandom) : 32'($urandom_range(0, 80000));
                rp.push_back(($urandom_range(0, 9) == 0) ? 4'd15 : 4'($urandom_range(0, 7)));
                rv.push_back(v);
                rprim.push_back($urandom_range(0, 7) != 0);
                m = model_decl(m, k, rp[k], rv[k], rprim[k]);
            end
            for (int k = 0; k < n; k++) put(rp[k], rv[k], rprim[k], k == n - 1);
            finish_elem($sformatf("rnd%0d", e), pack(m), m.err, $urandom_range(0, 2));
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
